// File: rtl/ram_access_ctrl.sv
// Access sequencer for the 256x16 display RAM: turns step/write pulses into RAM cycles
// and reads the addressed word back for the display. Optional auto-scan: `define AUTO_SCAN_EN.
module ram_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
`ifdef AUTO_SCAN_EN
    , parameter int SCAN_TICKS = 50_000_000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
`ifdef AUTO_SCAN_EN
    input  logic              scan_en,
`endif
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              data_valid,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] din_reg, din_next;
    logic [ADDR_W-1:0] disp_addr_reg;
    logic [DATA_W-1:0] disp_data_reg;
    logic              data_valid_reg;
    logic              scan_take;

`ifdef AUTO_SCAN_EN
    localparam int CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_TICKS - 1);

    logic [CNT_W-1:0] scan_cnt_reg;
    logic             scan_pend_reg;

    // A wrap re-arms the pending tick even in the cycle it is consumed.
    always_ff @(posedge clk) begin
        if (reset || !scan_en) begin
            scan_cnt_reg  <= '0;
            scan_pend_reg <= 1'b0;
        end else begin
            if (scan_cnt_reg == CNT_LAST) begin
                scan_cnt_reg  <= '0;
                scan_pend_reg <= 1'b1;
            end else begin
                scan_cnt_reg  <= scan_cnt_reg + 1'b1;
                if (scan_take)
                    scan_pend_reg <= 1'b0;
            end
        end
    end
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= READ;
            addr_reg       <= '0;
            din_reg        <= '0;
            disp_addr_reg  <= '0;
            disp_data_reg  <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            din_reg        <= din_next;
            data_valid_reg <= (state_reg == WAIT);
            if (state_reg == WAIT) begin
                disp_data_reg <= ram_dout;
                disp_addr_reg <= addr_reg;
            end
        end
    end

    // Next-state logic; address arithmetic wraps naturally at 2**ADDR_W
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        din_next   = din_reg;
        scan_take  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wr_req) begin
                    din_next   = wr_data;
                    state_next = WRITE;
                end else if (inc && !dec) begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = READ;
                end else if (dec && !inc) begin
                    addr_next  = addr_reg - 1'b1;
                    state_next = READ;
`ifdef AUTO_SCAN_EN
                end else if (!inc && !dec && scan_pend_reg) begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = READ;
                    scan_take  = 1'b1;
`endif
                end
            end
            WRITE:   state_next = READ;
            READ:    state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_we     = (state_reg == WRITE) && !reset;
        ram_addr   = addr_reg;
        ram_din    = din_reg;
        disp_addr  = disp_addr_reg;
        disp_data  = disp_data_reg;
        data_valid = data_valid_reg;
        busy       = (state_reg != IDLE);
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural RAM plus an address/contents model,
// directed corner cases followed by random inc/dec/write traffic.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        inc, dec, wr_req;
    logic [15:0] wr_data;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  disp_addr;
    logic [15:0] disp_data;
    logic        data_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic [15:0] model_mem [256];
    int          model_addr;

    always #5 clk = ~clk;

    ram_access_ctrl dut (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .wr_req(wr_req),
        .wr_data(wr_data), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .disp_addr(disp_addr), .disp_data(disp_data),
        .data_valid(data_valid), .busy(busy)
    );

    // Synchronous RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // kind: 0 = inc, 1 = dec, 2 = write
    task automatic do_op(input int kind, input logic [15:0] d);
        int lat;
        int we_cnt;
        int exp_lat;
        wait_idle();
        inc     = (kind == 0);
        dec     = (kind == 1);
        wr_req  = (kind == 2);
        wr_data = (kind == 2) ? d : 16'($urandom);
        if (kind == 0) model_addr = (model_addr + 1) % 256;
        if (kind == 1) model_addr = (model_addr + 255) % 256;
        if (kind == 2) model_mem[model_addr] = d;
        exp_lat = (kind == 2) ? 4 : 3;
        tick();
        inc = 1'b0; dec = 1'b0; wr_req = 1'b0;
        wr_data = 16'($urandom);
        lat = 1;
        we_cnt = 0;
        if (kind == 2) begin
            chk("we_at_n1", {31'd0, ram_we}, 32'd1);
            chk("we_addr", {24'd0, ram_addr}, model_addr);
            chk("we_din", {16'd0, ram_din}, {16'd0, d});
        end
        while (data_valid !== 1'b1 && lat < 10) begin
            if (ram_we === 1'b1) we_cnt++;
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("we_count", we_cnt, (kind == 2) ? 1 : 0);
        chk("disp_addr", {24'd0, disp_addr}, model_addr);
        chk("disp_data", {16'd0, disp_data}, {16'd0, model_mem[model_addr]});
        $display("op kind=%0d data=%04h -> addr=%0d disp=%04h lat=%0d", kind, d, disp_addr, disp_data, lat);
        tick();
        chk("dv_pulse", {31'd0, data_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int dv_cnt;
        int saved_addr;
        reset = 1'b1; inc = 1'b0; dec = 1'b0; wr_req = 1'b0; wr_data = 16'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            model_mem[i] = mem[i];
        end
        mem[0] = 16'hBEEF;
        model_mem[0] = 16'hBEEF;
        model_addr = 0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_disp_data", {16'd0, disp_data}, 32'd0);
        chk("rst_disp_addr", {24'd0, disp_addr}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_din", {16'd0, ram_din}, 32'd0);
        reset = 1'b0;
        lat = 0;
        while (data_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("post_rst_lat", lat, 2);
        chk("post_rst_data", {16'd0, disp_data}, 32'h0000BEEF);
        chk("post_rst_addr", {24'd0, disp_addr}, 32'd0);
        $display("reset readback addr=%0d disp=%04h lat=%0d", disp_addr, disp_data, lat);

        // Write at 0, wrap down to 255, wrap up to 0
        do_op(2, 16'h1234);
        do_op(1, 16'h0);
        do_op(0, 16'h0);

        // inc and dec together: no access at all
        wait_idle();
        inc = 1'b1; dec = 1'b1;
        tick();
        inc = 1'b0; dec = 1'b0;
        chk("incdec_busy", {31'd0, busy}, 32'd0);
        dv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (data_valid === 1'b1 || busy === 1'b1) dv_cnt++;
            tick();
        end
        chk("incdec_noaccess", dv_cnt, 0);
        chk("incdec_addr", {24'd0, ram_addr}, model_addr);
        $display("inc+dec no-op addr=%0d", ram_addr);

        // inc held while busy: only the first one counts
        wait_idle();
        inc = 1'b1;
        model_addr = (model_addr + 1) % 256;
        tick();
        chk("busy_after_inc", {31'd0, busy}, 32'd1);
        tick(); tick();
        inc = 1'b0;
        lat = 0;
        while (data_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("drop_disp_addr", {24'd0, disp_addr}, model_addr);
        tick(); tick(); tick();
        chk("drop_addr", {24'd0, ram_addr}, model_addr);
        chk("drop_idle", {31'd0, busy}, 32'd0);
        $display("inc during busy dropped addr=%0d", ram_addr);

        // Random traffic
        for (int i = 0; i < 40; i++)
            do_op(int'($urandom_range(2, 0)), 16'($urandom));

        // Reset during the WRITE cycle
        if (model_addr == 0) do_op(0, 16'h0);
        saved_addr = model_addr;
        wait_idle();
        wr_req = 1'b1; wr_data = 16'hDEAD;
        tick();
        wr_req = 1'b0;
        chk("abort_we_pre", {31'd0, ram_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_we_gated", {31'd0, ram_we}, 32'd0);
        tick();
        reset = 1'b0;
        model_addr = 0;
        lat = 0;
        while (data_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("abort_lat", lat, 2);
        chk("abort_disp_addr", {24'd0, disp_addr}, 32'd0);
        chk("abort_disp_data", {16'd0, disp_data}, {16'd0, model_mem[0]});
        chk("abort_mem_kept", {16'd0, mem[saved_addr]}, {16'd0, model_mem[saved_addr]});
        $display("reset during write addr=%0d disp=%04h", disp_addr, disp_data);

        do_op(0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
